// File: rtl/intr_sequencer_if.sv
// intr_sequencer_if: bundles the controller handshake (IRQ/isr_addr/IACK), CPU retire/mret
// boundary inputs, gie config write and the PC redirect/status outputs of intr_sequencer.
interface intr_sequencer_if #(
    parameter int AW = 32
);
    logic          IRQ;
    logic [AW-1:0] isr_addr;
    logic          IACK;
    logic          retire;
    logic [AW-1:0] pc_next_seq;
    logic          mret;
    logic          cfg_we;
    logic [AW-1:0] cfg_wdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] epc;
    logic          in_isr;
    logic          gie;

    modport slave (
        input  IRQ, isr_addr, retire, pc_next_seq, mret, cfg_we, cfg_wdata,
        output IACK, redirect, redirect_pc, epc, in_isr, gie
    );

    modport master (
        output IRQ, isr_addr, retire, pc_next_seq, mret, cfg_we, cfg_wdata,
        input  IACK, redirect, redirect_pc, epc, in_isr, gie
    );
endinterface

// File: rtl/intr_sequencer.sv
// intr_sequencer: takes a level IRQ at a retire boundary, acknowledges it, saves the return PC,
// redirects fetch to the ISR and restores the PC on mret (single level, no nesting).
// Optional statistics (irq_count, max_latency) are built when INTR_SEQ_STATS_EN is defined.
module intr_sequencer #(
    parameter int AW = 32
`ifdef INTR_SEQ_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    intr_sequencer_if.slave bus
`ifdef INTR_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0] irq_count,
    output logic [CNT_W-1:0] max_latency
`endif
);
    typedef enum logic [2:0] {IDLE, WAIT_RET, ACK, REDIRECT, IN_ISR, RETURN} state_t;

    state_t        state_q, state_d;
    logic          iack_q, iack_d;
    logic          redirect_q, redirect_d;
    logic          in_isr_q, in_isr_d;
    logic          gie_q, gie_d;
    logic [AW-1:0] redirect_pc_q, redirect_pc_d;
    logic [AW-1:0] epc_q, epc_d;
    logic [AW-1:0] isr_lat_q, isr_lat_d;
    logic          gie_wr;
    logic          enter_ack;
    logic          enter_ret;
    logic          unused_wdata;

    assign unused_wdata = ^bus.cfg_wdata[AW-1:1];

    // next state plus the values every output flop takes in that state
    always_comb begin
        gie_wr = bus.cfg_we ? bus.cfg_wdata[0] : gie_q;
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = (bus.IRQ && gie_q) ? WAIT_RET : IDLE;
            WAIT_RET: state_d = !bus.IRQ ? IDLE : bus.retire ? ACK : !gie_wr ? IDLE : WAIT_RET;
            ACK:      state_d = REDIRECT;
            REDIRECT: state_d = IN_ISR;
            IN_ISR:   state_d = bus.mret ? RETURN : IN_ISR;
            default:  state_d = IDLE;
        endcase
        enter_ack = (state_q == WAIT_RET) && (state_d == ACK);
        enter_ret = (state_q == IN_ISR) && (state_d == RETURN);
        gie_d = enter_ack ? 1'b0 : enter_ret ? 1'b1 : gie_wr;
        epc_d = enter_ack ? bus.pc_next_seq : epc_q;
        isr_lat_d = enter_ack ? bus.isr_addr : isr_lat_q;
        iack_d = state_d == ACK;
        redirect_d = (state_d == REDIRECT) || (state_d == RETURN);
        redirect_pc_d = (state_d == REDIRECT) ? isr_lat_q : (state_d == RETURN) ? epc_q : '0;
        in_isr_d = state_d == IN_ISR;
    end

    // state and registered outputs; reset drops everything at once, mid-sequence included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            iack_q        <= 1'b0;
            redirect_q    <= 1'b0;
            in_isr_q      <= 1'b0;
            gie_q         <= 1'b0;
            redirect_pc_q <= '0;
            epc_q         <= '0;
            isr_lat_q     <= '0;
        end else begin
            state_q       <= state_d;
            iack_q        <= iack_d;
            redirect_q    <= redirect_d;
            in_isr_q      <= in_isr_d;
            gie_q         <= gie_d;
            redirect_pc_q <= redirect_pc_d;
            epc_q         <= epc_d;
            isr_lat_q     <= isr_lat_d;
        end
    end

    assign bus.IACK        = iack_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.epc         = epc_q;
    assign bus.in_isr      = in_isr_q;
    assign bus.gie         = gie_q;

`ifdef INTR_SEQ_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] lat_inc;

    // lat_q counts WAIT_RET cycles already spent; the ACK-side value includes the current one
    always_comb begin
        lat_inc = &lat_q ? lat_q : lat_q + 1'b1;
        lat_d = (state_q == WAIT_RET) ? lat_inc : '0;
        cnt_d = (enter_ack && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        max_d = (enter_ack && (lat_inc > max_q)) ? lat_inc : max_q;
    end

    // saturating statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            lat_q <= '0;
            max_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lat_q <= lat_d;
            max_q <= max_d;
        end
    end

    assign irq_count   = cnt_q;
    assign max_latency = max_q;
`endif

    // IACK and redirect are exclusive and never last more than one cycle
    assert property (@(posedge clk) disable iff (!rst) !(iack_q && redirect_q));
    assert property (@(posedge clk) disable iff (!rst) iack_q |=> !iack_q);
    assert property (@(posedge clk) disable iff (!rst) redirect_q |=> !redirect_q);
endmodule
